// File: rtl/cnn_sweep_ctrl_pkg.sv
// Shared types and sizing helpers for the CNN sweep controller.
package cnn_ctrl_pkg;

   localparam int N_CELLS_DEF = 16;
   localparam int SW_DEF      = 9;
   localparam int ITW_DEF     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_DRAIN,
      ST_COMMIT,
      ST_DONE
   } ctrl_state_e;

   // Width needed to index n items; never narrower than one bit.
   function automatic int cnn_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cnn_sweep_ctrl_if.sv
// Host-control and datapath-facing signals of the sweep controller.
interface cnn_sweep_ctrl_if
   import cnn_ctrl_pkg::*;
#(
   parameter int N_CELLS = N_CELLS_DEF,
   parameter int SW      = SW_DEF,
   parameter int ITW     = ITW_DEF
);
   localparam int IW = cnn_idx_w(N_CELLS);

   logic                  start;
   logic                  abort;
   logic [ITW-1:0]        max_iter;
   logic                  load_tmpl;
   logic                  cell_valid;
   logic [IW-1:0]         cell_idx;
   logic signed [SW-1:0]  cell_out;
   logic signed [SW-1:0]  cell_prev;
   logic                  commit;
   logic                  busy;
   logic                  done;
   logic                  converged;
   logic [ITW-1:0]        iter_count;

   modport master (
      input  start, abort, max_iter, cell_out, cell_prev,
      output load_tmpl, cell_valid, cell_idx, commit, busy, done, converged, iter_count
   );

   modport slave (
      output start, abort, max_iter, cell_out, cell_prev,
      input  load_tmpl, cell_valid, cell_idx, commit, busy, done, converged, iter_count
   );
endinterface

// File: rtl/cnn_sweep_ctrl_valid_pipe.sv
// Delays cell_valid by the datapath latency so results can be qualified.
module cnn_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic vld_in,
   output logic res_vld
);
   logic [DEPTH-1:0] vld_q, vld_d;

   always_comb begin
      vld_d = '0;
      if (!clr) begin
         vld_d[0] = vld_in;
         for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      vld_q <= vld_d;
   end

   assign res_vld = vld_q[DEPTH-1];
endmodule

// File: rtl/cnn_sweep_ctrl.sv
// Sweep sequencer for the shared single-cell CNN evaluator: load, issue, drain, commit, repeat.
module cnn_sweep_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int N_CELLS = N_CELLS_DEF,
   parameter int DP_LAT  = 2,
   parameter int SW      = SW_DEF,
   parameter int ITW     = ITW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   cnn_sweep_ctrl_if.master bus
);
   localparam int            IW       = cnn_idx_w(N_CELLS);
   localparam int            DW       = cnn_idx_w(DP_LAT + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_CELLS - 1);

   ctrl_state_e          state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic [ITW-1:0]       iter_q, iter_d;
   logic [ITW-1:0]       limit_q, limit_d;
   logic                 changed_q, changed_d;
   logic                 conv_q, conv_d;
   logic                 res_valid;
   logic                 issuing;
   logic signed [SW-1:0] res_cur, res_prev;

   assign issuing  = (state_q == ST_ISSUE);
   assign res_cur  = bus.cell_out;
   assign res_prev = bus.cell_prev;

   cnn_valid_pipe #(.DEPTH(DP_LAT)) u_valid_pipe (
      .clk     (clk),
      .clr     (rst | bus.abort),
      .vld_in  (issuing),
      .res_vld (res_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         drain_q   <= '0;
         iter_q    <= '0;
         limit_q   <= '0;
         changed_q <= 1'b0;
         conv_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         drain_q   <= drain_d;
         iter_q    <= iter_d;
         limit_q   <= limit_d;
         changed_q <= changed_d;
         conv_q    <= conv_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      drain_d   = drain_q;
      iter_d    = iter_q;
      limit_d   = limit_q;
      changed_d = changed_q;
      conv_d    = conv_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               limit_d = (bus.max_iter == '0) ? ITW'(1) : bus.max_iter;
               iter_d  = '0;
               conv_d  = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            changed_d = 1'b0;
            idx_d     = '0;
            state_d   = ST_ISSUE;
         end
         ST_ISSUE: begin
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               drain_d = DW'(DP_LAT);
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            iter_d = iter_q + ITW'(1);
            if (!changed_q) begin
               conv_d  = 1'b1;
               state_d = ST_DONE;
            end else if (iter_q + ITW'(1) == limit_q) begin
               state_d = ST_DONE;
            end else begin
               changed_d = 1'b0;
               idx_d     = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // The last result of a sweep lands in the final DRAIN cycle and must still count.
      if (res_valid && (res_cur != res_prev)) changed_d = 1'b1;
      if (bus.abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         iter_d  = iter_q;
         conv_d  = 1'b0;
      end
   end

   always_comb begin
      bus.load_tmpl  = (state_q == ST_LOAD);
      bus.cell_valid = issuing;
      bus.cell_idx   = issuing ? idx_q : '0;
      bus.commit     = (state_q == ST_COMMIT) && !bus.abort;
      bus.done       = (state_q == ST_DONE) && !bus.abort;
      bus.busy       = (state_q != ST_IDLE);
      bus.converged  = conv_q;
      bus.iter_count = iter_q;
   end
endmodule

// File: tb/tb_cnn_sweep_ctrl.sv
// Scoreboard bench for cnn_sweep_ctrl with a 2-cycle behavioural datapath model.
module tb_cnn_sweep_ctrl;
   import cnn_ctrl_pkg::*;

   localparam int DP_LAT = 2;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } ev_t;

   logic clk;
   logic rst;
   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   mode = 0;
   bit   mon_en = 0;
   ev_t  exp_q[$];

   cnn_sweep_ctrl_if #(.N_CELLS(16), .SW(9), .ITW(8)) bus ();

   cnn_sweep_ctrl #(.N_CELLS(16), .DP_LAT(DP_LAT), .SW(9), .ITW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: result and committed state arrive DP_LAT cycles after issue.
   logic              v1, v2, diff;
   logic [3:0]        i1, i2;
   logic signed [8:0] p1, p2;
   int                sweep_n = 0;

   always @(posedge clk) begin
      v1 <= bus.cell_valid;
      v2 <= v1;
      i1 <= bus.cell_idx;
      i2 <= i1;
      p1 <= 9'($urandom);
      p2 <= p1;
      if (bus.load_tmpl) sweep_n <= 0;
      else if (bus.commit) sweep_n <= sweep_n + 1;
   end

   // Idle result slots always differ so an unqualified compare would be caught.
   always_comb begin
      diff = !v2 || (mode == 1) || (mode == 2 && sweep_n == 0 && i2 == 4'd15);
      bus.cell_prev = p2;
      bus.cell_out  = diff ? $signed(p2 ^ 9'h100) : p2;
   end

   task automatic check_val(input string tag, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic expect_ev(input int c, input int k, input int v);
      ev_t e;
      e.cyc = c;
      e.kind = k;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic match_ev(input int k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         check_val("unexpected_evt", k, -1);
         return;
      end
      e = exp_q.pop_front();
      check_val("evt_kind", k, e.kind);
      check_val("evt_cyc", cyc, e.cyc);
      check_val("evt_val", v, e.val);
   endtask

   // kinds: 0 load_tmpl, 1 cell_idx, 2 commit, 3 done (converged*256 + iter_count)
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.load_tmpl) match_ev(0, 0);
         if (bus.cell_valid) match_ev(1, int'(bus.cell_idx));
         if (bus.commit) match_ev(2, 0);
         if (bus.done) match_ev(3, int'(bus.converged) * 256 + int'(bus.iter_count));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_run(input int t0, input int sweeps, input int conv, input int iters);
      expect_ev(t0 + 1, 0, 0);
      for (int s = 0; s < sweeps; s++) begin
         for (int k = 0; k < 16; k++) expect_ev(t0 + 2 + 19 * s + k, 1, k);
         expect_ev(t0 + 20 + 19 * s, 2, 0);
      end
      expect_ev(t0 + 21 + 19 * (sweeps - 1), 3, conv * 256 + iters);
   endtask

   task automatic check_idle_zero(input string tag);
      check_val({tag, "_busy"}, int'(bus.busy), 0);
      check_val({tag, "_done"}, int'(bus.done), 0);
      check_val({tag, "_conv"}, int'(bus.converged), 0);
      check_val({tag, "_iter"}, int'(bus.iter_count), 0);
      check_val({tag, "_load"}, int'(bus.load_tmpl), 0);
      check_val({tag, "_valid"}, int'(bus.cell_valid), 0);
      check_val({tag, "_idx"}, int'(bus.cell_idx), 0);
      check_val({tag, "_commit"}, int'(bus.commit), 0);
   endtask

   task automatic run_full(input int m, input int mi, input int sweeps, input int conv,
                           input int iters, input bit poke);
      int t0;
      mode = m;
      bus.max_iter = 8'(mi);
      bus.start = 1'b1;
      t0 = cyc;
      push_run(t0, sweeps, conv, iters);
      step(1);
      bus.start = 1'b0;
      while (cyc < t0 + 23 + 19 * (sweeps - 1)) begin
         bus.start = poke && (cyc == t0 + 5 || cyc == t0 + 21);
         step(1);
      end
      bus.start = 1'b0;
      check_val("run_q_empty", exp_q.size(), 0);
      check_val("run_hold_iter", int'(bus.iter_count), iters);
      check_val("run_hold_conv", int'(bus.converged), conv);
      check_val("run_idle", int'(bus.busy), 0);
   endtask

   task automatic abort_case(input int m, input int at, input int exp_iter);
      int t0;
      mode = m;
      bus.max_iter = 8'd5;
      bus.start = 1'b1;
      t0 = cyc;
      expect_ev(t0 + 1, 0, 0);
      for (int k = 0; k < 16; k++) if (2 + k <= at) expect_ev(t0 + 2 + k, 1, k);
      if (at >= 21) expect_ev(t0 + 20, 2, 0);
      step(1);
      bus.start = 1'b0;
      while (cyc < t0 + at) step(1);
      bus.abort = 1'b1;
      step(1);
      bus.abort = 1'b0;
      check_val("abort_busy", int'(bus.busy), 0);
      check_val("abort_iter", int'(bus.iter_count), exp_iter);
      check_val("abort_conv", int'(bus.converged), 0);
      check_val("abort_done", int'(bus.done), 0);
      step(3);
      check_val("abort_q_empty", exp_q.size(), 0);
      check_val("abort_still_idle", int'(bus.busy), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.max_iter = '0;
      step(3);
      rst = 1'b0;
      check_idle_zero("reset");
      mon_en = 1'b1;

      run_full(0, 5, 1, 1, 1, 1'b0);
      run_full(1, 3, 3, 0, 3, 1'b0);
      run_full(2, 10, 2, 1, 2, 1'b0);
      run_full(1, 0, 1, 0, 1, 1'b0);

      abort_case(1, 10, 0);
      abort_case(1, 20, 0);
      abort_case(0, 21, 1);

      // abort beats start while idle
      bus.start = 1'b1;
      bus.abort = 1'b1;
      step(1);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_val("idle_abort_busy", int'(bus.busy), 0);
      step(2);
      check_val("idle_abort_busy2", int'(bus.busy), 0);
      check_val("idle_abort_q", exp_q.size(), 0);

      // reset landing on a COMMIT cycle
      mode = 1;
      bus.max_iter = 8'd3;
      bus.start = 1'b1;
      t0 = cyc;
      expect_ev(t0 + 1, 0, 0);
      for (int k = 0; k < 16; k++) expect_ev(t0 + 2 + k, 1, k);
      expect_ev(t0 + 20, 2, 0);
      step(1);
      bus.start = 1'b0;
      while (cyc < t0 + 20) step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_idle_zero("midrst");
      check_val("midrst_q", exp_q.size(), 0);
      step(1);
      run_full(0, 5, 1, 1, 1, 1'b1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/cnn_sweep_ctrl.md
Name: cnn_sweep_ctrl

Overview:
Sequencer for the shared single-cell CNN evaluator used by the 4x4 array.
- Loads templates, then issues cell indices 0..N_CELLS-1 once per cycle to form one sweep.
- Commits the new state vector at the end of each sweep.
- Repeats sweeps until no cell changes (converged) or the requested iteration limit is reached.
- Sits between the host/top-level start logic and the 4x4 datapath, replacing the datapath's free-running counter.

Parameters:
N_CELLS, 16, cells per sweep; cell_idx width is clog2(N_CELLS).
DP_LAT, 2, cycles from cell_valid/cell_idx to the matching cell_out/cell_prev; must be >= 1.
SW, 9, signed state width of cell_out/cell_prev.
ITW, 8, width of max_iter/iter_count.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
abort  in  1  cancel run; honoured in any non-IDLE state
max_iter  in  ITW  sweep limit, latched on accepted start; 0 treated as 1
load_tmpl  out  1  1-cycle pulse; datapath captures A/B/I/U registers
cell_valid  out  1  high while issuing cell_idx
cell_idx  out  4  cell being evaluated (0..15)
cell_out  in  SW signed  datapath result for the cell issued DP_LAT cycles earlier
cell_prev  in  SW signed  committed state of the same cell, aligned with cell_out
commit  out  1  1-cycle pulse; datapath copies Y_next into Y
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at end of run
converged  out  1  run ended because a full sweep produced no change
iter_count  out  ITW  sweeps committed in the current/last run

Behaviour:
- Reset (any time, including mid-run): state IDLE; all outputs 0; changed flag cleared; valid pipe cleared.
- States: IDLE, LOAD, ISSUE, DRAIN, COMMIT, DONE.
- IDLE:
  - start=1 and abort=0: latch max_iter (0→1); clear iter_count and converged; go to LOAD.
  - abort=1 wins over start; stay in IDLE.
- LOAD: load_tmpl=1 for one cycle; clear changed; go to ISSUE with idx=0.
- ISSUE:
  - cell_valid=1, cell_idx=idx; idx increments each cycle.
  - At idx=N_CELLS-1, go to DRAIN with a drain counter of DP_LAT.
- DRAIN: lasts exactly DP_LAT cycles, with cell_valid=0.
- Result tracking (every state):
  - res_valid = cell_valid delayed DP_LAT cycles.
  - Whenever res_valid=1 and cell_out != cell_prev, set changed (sticky).
  - The last result of a sweep arrives in the final DRAIN cycle.
- COMMIT:
  - commit=1; iter_count increments.
  - changed=0 → DONE with converged=1.
  - Else if iter_count+1 == latched limit → DONE with converged=0.
  - Else clear changed and go to ISSUE with idx=0. No reload.
- DONE: done=1 for one cycle; go to IDLE. converged and iter_count hold until the next accepted start.
- Timing, DP_LAT=2, start high in cycle 0:
  - LOAD in cycle 1; ISSUE in cycles 2-17; DRAIN in 18-19; COMMIT in 20; DONE (done=1) in 21.
  - Each further sweep adds 19 cycles (N_CELLS + DP_LAT + 1).
- abort in LOAD/ISSUE/DRAIN/COMMIT/DONE:
  - Next state is IDLE; no done pulse; no commit in that cycle.
  - The valid pipe is flushed; iter_count keeps its value; converged=0.
- start while busy is ignored.
- Comparison is a signed, full-width equality; no tolerance.
- iter_count never exceeds the latched limit, so it cannot wrap.

Decomposition:
- Package cnn_ctrl_pkg holds:
  - the state enum;
  - N_CELLS_DEF=16, SW_DEF=9, ITW_DEF=8;
  - the cell-index width function.
- One sub-module, cnn_valid_pipe: DP_LAT-deep shift register carrying cell_valid, with synchronous clear (driven by rst or abort) producing res_valid.
- Everything else is in the top FSM.

Test Plan:
- Reset, then start=1 for 1 cycle, max_iter=5, cell_out==cell_prev always → load_tmpl in cycle 1; idx 0..15 in cycles 2-17; commit in 20; done+converged=1 in 21; iter_count=1.
- max_iter=3, cell_out always differs from cell_prev → 3 commit pulses at cycles 20, 39, 58; done in 59; converged=0; iter_count=3.
- Change only on cell 15 during sweep 1, none in sweep 2, max_iter=10 → converged=1, iter_count=2; proves the final DRAIN-cycle result is counted.
- max_iter=0 with constant change → exactly 1 sweep; done with converged=0, iter_count=1.
- abort in cycle 10 (mid-ISSUE) → IDLE next cycle; busy=0; no done, no commit; start in the same cycle as abort while in IDLE → stays IDLE.
- rst asserted in a COMMIT cycle → next cycle all outputs 0; a start 2 cycles later runs the normal 21-cycle sequence; start pulses while busy are ignored.
